fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Control FSM upstream of the FFT done-status register.
//  - On a start pulse, steps the radix-2 DIF butterfly datapath through LOG2N stages of N_POINTS/2 butterflies each.
//  - Per butterfly, issues SRAM operand addresses and a twiddle index over a valid/ready handshake.
//  - Inserts a pipeline drain between stages; raises active-high core_done when the transform completes.
// PARAMETERS
//  N_POINTS    256  transform size; power of two, >= 4
//  LOG2N       8    $clog2(N_POINTS); number of stages
//  BF_LATENCY  3    butterfly pipeline depth; idle drain cycles after each stage, 0 allowed
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               reset: asynchronous, active-low
//  start_fft    in   1               start request, sampled in IDLE/DONE only
//  clear_done   in   1               DONE -> IDLE, drops core_done
//  bf_ready     in   1               datapath/SRAM arbiter accepts the current butterfly
//  bf_valid     out  1               butterfly request valid
//  bf_addr_a    out  LOG2N           upper-leg SRAM address
//  bf_addr_b    out  LOG2N           lower-leg SRAM address (bf_addr_a + span)
//  bf_twiddle   out  LOG2N-1         twiddle ROM index
//  bf_stage     out  $clog2(LOG2N)   current stage number
//  busy         out  1               high in ISSUE or DRAIN
//  core_done    out  1               level; high in DONE only
// BEHAVIOUR
//  Reset values: every output 0; state IDLE; stage/k/drain counters 0. An async reset mid-transform aborts immediately with no completion.
//  States:
//   IDLE  -> ISSUE on start_fft.
//   ISSUE -> DRAIN after the last handshake of a stage.
//   DRAIN -> ISSUE (next stage) or DONE (last stage) once BF_LATENCY cycles have elapsed.
//   DONE  -> ISSUE on start_fft; -> IDLE on clear_done. start_fft has priority if both are high.
//  start_fft in ISSUE/DRAIN is ignored; there is no restart while busy.
//  ISSUE:
//   - bf_valid=1.
//   - Handshake = bf_valid & bf_ready; k increments on it.
//   - While bf_ready=0, all bf_* outputs are held stable.
//  Address math for stage s, butterfly k (0..N/2-1):
//   span = N>>(s+1); grp = k/span; pos = k%span
//   addr_a = grp*2*span + pos; addr_b = addr_a + span
//   twiddle = pos<<s
//   Computed with shifts/masks only (no dividers); widths truncate to LOG2N.
//  DRAIN:
//   - bf_valid=0; counts BF_LATENCY cycles.
//   - BF_LATENCY=0: ISSUE goes directly to the next ISSUE or DONE.
//  core_done:
//   - Rises on the edge leaving the final DRAIN.
//   - Falls on the edge leaving DONE, when ISSUE or IDLE is entered.
//  Latency with bf_ready tied high: core_done rises LOG2N*(N/2+BF_LATENCY) edges after the edge sampling start_fft.
// CONFIGURATION
//  FFT_SEQ_PERF_CNT_EN defined:
//   - Adds output perf_cycles[31:0], reset 0.
//   - Cleared when start_fft is accepted; +1 every cycle in ISSUE/DRAIN; saturates at 32'hFFFF_FFFF.
//   - Holds its value in DONE/IDLE.
//  FFT_SEQ_PERF_CNT_EN undefined: no port, no counter logic.
// STRUCTURE
//  fft_pkg holds the fft_seq_state_e enum (IDLE, ISSUE, DRAIN, DONE), N_POINTS/LOG2N defaults, and address-width typedefs.
//  Sub-module fft_bf_addr_gen: purely combinational (stage, k) -> (addr_a, addr_b, twiddle); the FSM/counters stay in the top.
// TESTING (N_POINTS=16, LOG2N=4, BF_LATENCY=3 unless noted)
//  1. start_fft 1-cycle pulse, bf_ready=1:
//     - bf_valid for 8 cycles per stage with 3-cycle gaps.
//     - core_done rises exactly 44 edges after start; busy=0 and core_done=1 afterwards.
//  2. Address check:
//     - stage0 k=0 -> a=0,b=8,tw=0; stage0 k=7 -> a=7,b=15,tw=7.
//     - stage1 k=5 -> a=9,b=13,tw=2; stage3 k=3 -> a=6,b=7,tw=0.
//  3. Backpressure: bf_ready low 5 cycles mid-stage1 -> outputs frozen, no k skip or duplicate; core_done at 49 edges.
//  4. start_fft while busy -> ignored; start in DONE -> core_done drops next edge, stage0 k=0 reissued; clear_done in DONE -> IDLE, core_done=0.
//  5. rst_n low mid-stage2 -> all outputs 0 asynchronously; after release, no core_done until a new start.
//  6. BF_LATENCY=0 -> no bf_valid gaps, core_done at 32 edges; with FFT_SEQ_PERF_CNT_EN, perf_cycles=44 in the default config.

Source files
------------

// File: rtl/fft_stage_sequencer_pkg.sv
// fft_pkg: shared state encoding, default geometry and address typedefs for
// the FFT stage sequencer slice.
package fft_pkg;

   localparam int N_POINTS_DEF   = 256;
   localparam int LOG2N_DEF      = 8;
   localparam int BF_LATENCY_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fft_seq_state_e;

   // Address/twiddle/stage widths for the default transform size.
   typedef logic [LOG2N_DEF-1:0]         fft_addr_t;
   typedef logic [LOG2N_DEF-2:0]         fft_twiddle_t;
   typedef logic [$clog2(LOG2N_DEF)-1:0] fft_stage_t;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Butterfly request channel between the stage sequencer (master) and the
// datapath / SRAM arbiter (slave). One butterfly per bf_valid & bf_ready.
interface fft_stage_sequencer_if
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF
) ();
   localparam int SW = $clog2(LOG2N);

   logic             bf_valid;
   logic             bf_ready;
   logic [LOG2N-1:0] bf_addr_a;
   logic [LOG2N-1:0] bf_addr_b;
   logic [LOG2N-2:0] bf_twiddle;
   logic [SW-1:0]    bf_stage;

   modport master (
      output bf_valid, bf_addr_a, bf_addr_b, bf_twiddle, bf_stage,
      input  bf_ready
   );

   modport slave (
      input  bf_valid, bf_addr_a, bf_addr_b, bf_twiddle, bf_stage,
      output bf_ready
   );
endinterface

// File: rtl/fft_stage_sequencer_bf_addr_gen.sv
// fft_bf_addr_gen: combinational radix-2 DIF butterfly address generator.
// For stage s and butterfly k: span = (N/2)>>s, the low bits of k below span
// give the position inside a group and the high bits select the group, so the
// usual k/span and k%span reduce to masks and a 1-bit shift.
module fft_bf_addr_gen
   import fft_pkg::*;
#(
   parameter int N_POINTS = N_POINTS_DEF,
   parameter int LOG2N    = LOG2N_DEF
) (
   input  logic [$clog2(LOG2N)-1:0] stage,
   input  logic [LOG2N-2:0]         k,
   output logic [LOG2N-1:0]         addr_a,
   output logic [LOG2N-1:0]         addr_b,
   output logic [LOG2N-2:0]         twiddle
);
   localparam logic [LOG2N-1:0] HALF = LOG2N'(N_POINTS / 2);

   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] mask;
   logic [LOG2N-1:0] k_ext;

   assign span    = HALF >> stage;
   assign mask    = span - LOG2N'(1);
   assign k_ext   = {1'b0, k};
   // Group bits move up by one to skip over the lower-leg half of each group.
   assign addr_a  = ((k_ext & ~mask) << 1) | (k_ext & mask);
   assign addr_b  = addr_a + span;
   assign twiddle = (LOG2N-1)'((k_ext & mask) << stage);

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: control FSM that walks a radix-2 DIF butterfly datapath
// through LOG2N stages of N_POINTS/2 butterflies, draining the pipeline for
// BF_LATENCY idle cycles between stages, then holds core_done until restarted
// or cleared.
// Optional feature macro: FFT_SEQ_PERF_CNT_EN adds the perf_cycles counter.
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int N_POINTS   = N_POINTS_DEF,
   parameter int LOG2N      = LOG2N_DEF,
   parameter int BF_LATENCY = BF_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_fft,
   input  logic                  clear_done,
   fft_stage_sequencer_if.master bf,
   output logic                  busy,
   output logic                  core_done
`ifdef FFT_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]           perf_cycles
`endif
);
   localparam int SW = $clog2(LOG2N);
   localparam int DW = (BF_LATENCY < 2) ? 1 : $clog2(BF_LATENCY);

   localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
   localparam logic [LOG2N-2:0] K_LAST     = '1;
   localparam logic [DW-1:0]    DRAIN_LAST = DW'((BF_LATENCY == 0) ? 0 : BF_LATENCY - 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0]       state_q;
   logic [SW-1:0]    stage_q;
   logic [LOG2N-2:0] k_q;
   logic [DW-1:0]    drain_q;

   logic             handshake;
   logic             start_ok;
   logic             last_stage;
   logic [LOG2N-1:0] gen_addr_a;
   logic [LOG2N-1:0] gen_addr_b;
   logic [LOG2N-2:0] gen_twiddle;

   assign handshake  = bf.bf_valid & bf.bf_ready;
   assign start_ok   = start_fft & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign last_stage = (stage_q == STAGE_LAST);

   fft_bf_addr_gen #(
      .N_POINTS (N_POINTS),
      .LOG2N    (LOG2N)
   ) u_addr_gen (
      .stage   (stage_q),
      .k       (k_q),
      .addr_a  (gen_addr_a),
      .addr_b  (gen_addr_b),
      .twiddle (gen_twiddle)
   );

   // State, stage, butterfly and drain counters; k only advances on a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         case (state_q)
            S_IDLE: begin
               if (start_fft) begin
                  state_q <= S_ISSUE;
                  stage_q <= '0;
                  k_q     <= '0;
               end
            end
            S_ISSUE: begin
               if (handshake) begin
                  if (k_q == K_LAST) begin
                     k_q <= '0;
                     if (BF_LATENCY != 0) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                     end else if (last_stage) begin
                        state_q <= S_DONE;
                        stage_q <= '0;
                     end else begin
                        stage_q <= stage_q + SW'(1);
                     end
                  end else begin
                     k_q <= k_q + (LOG2N-1)'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  drain_q <= '0;
                  if (last_stage) begin
                     state_q <= S_DONE;
                     stage_q <= '0;
                  end else begin
                     state_q <= S_ISSUE;
                     stage_q <= stage_q + SW'(1);
                  end
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            default: begin
               // DONE: a new start wins over clear_done.
               if (start_fft) begin
                  state_q <= S_ISSUE;
                  stage_q <= '0;
                  k_q     <= '0;
               end else if (clear_done) begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Butterfly request outputs; addresses are driven only while issuing.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latch).
      bf.bf_valid   = 1'b0;
      bf.bf_addr_a  = '0;
      bf.bf_addr_b  = '0;
      bf.bf_twiddle = '0;
      if (state_q == S_ISSUE) begin
         bf.bf_valid   = 1'b1;
         bf.bf_addr_a  = gen_addr_a;
         bf.bf_addr_b  = gen_addr_b;
         bf.bf_twiddle = gen_twiddle;
      end
   end

   assign bf.bf_stage = stage_q;
   assign busy        = (state_q == S_ISSUE) | (state_q == S_DRAIN);
   assign core_done   = (state_q == S_DONE);

`ifdef FFT_SEQ_PERF_CNT_EN
   // Busy-cycle counter: cleared on an accepted start, saturating, holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
      end else if (start_ok) begin
         perf_cycles <= '0;
      end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`else
   // Without the counter, an accepted start has no further consumer.
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N_POINTS=16, LOG2N=4.
// u_dut0 uses BF_LATENCY=3 with a driven bf_ready; u_dut1 uses BF_LATENCY=0
// with bf_ready tied high.
module tb_fft_stage_sequencer;
   localparam int N  = 16;
   localparam int L  = 4;
   localparam int NB = N / 2;

   logic clk = 1'b0;
   logic rst_n;
   logic start_fft;
   logic clear_done;
   logic start1;
   logic busy0, done0, busy1, done1;
`ifdef FFT_SEQ_PERF_CNT_EN
   logic [31:0] perf0, perf1;
`endif

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int mark;
   int cap_a [4][8];
   int cap_b [4][8];
   int cap_t [4][8];

   fft_stage_sequencer_if #(.LOG2N(L)) bf0 ();
   fft_stage_sequencer_if #(.LOG2N(L)) bf1 ();

   assign bf1.bf_ready = 1'b1;

   fft_stage_sequencer #(.N_POINTS(N), .LOG2N(L), .BF_LATENCY(3)) u_dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_fft   (start_fft),
      .clear_done  (clear_done),
      .bf          (bf0),
      .busy        (busy0),
      .core_done   (done0)
`ifdef FFT_SEQ_PERF_CNT_EN
      ,
      .perf_cycles (perf0)
`endif
   );

   fft_stage_sequencer #(.N_POINTS(N), .LOG2N(L), .BF_LATENCY(0)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_fft   (start1),
      .clear_done  (1'b0),
      .bf          (bf1),
      .busy        (busy1),
      .core_done   (done1)
`ifdef FFT_SEQ_PERF_CNT_EN
      ,
      .perf_cycles (perf1)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference addressing written with plain division/modulo.
   task automatic check_bf(input string tag, input int s, input int k,
                           input logic v, input logic [1:0] st,
                           input logic [3:0] a, input logic [3:0] b, input logic [2:0] tw);
      int span, grp, pos, ea;
      span = N >> (s + 1);
      grp  = k / span;
      pos  = k % span;
      ea   = grp * 2 * span + pos;
      check($sformatf("%s s%0d k%0d valid", tag, s, k), 32'(v), 32'd1);
      check($sformatf("%s s%0d k%0d stage", tag, s, k), 32'(st), 32'(s));
      check($sformatf("%s s%0d k%0d addr_a", tag, s, k), 32'(a), 32'(ea));
      check($sformatf("%s s%0d k%0d addr_b", tag, s, k), 32'(b), 32'(ea + span));
      check($sformatf("%s s%0d k%0d twiddle", tag, s, k), 32'(tw), 32'(pos << s));
   endtask

   // One full stage on u_dut0: optional bf_ready stall before butterfly stall_k,
   // optional start_fft poke during the drain, then BF_LATENCY=3 idle cycles.
   task automatic run_stage(input int s, input int stall_k, input int stall_len, input bit poke);
      for (int k = 0; k < NB; k++) begin
         if (k == stall_k) begin
            bf0.bf_ready = 1'b0;
            for (int c = 0; c < stall_len; c++) begin
               check_bf("stall", s, k, bf0.bf_valid, bf0.bf_stage,
                        bf0.bf_addr_a, bf0.bf_addr_b, bf0.bf_twiddle);
               nedge();
            end
            bf0.bf_ready = 1'b1;
         end
         check_bf("issue", s, k, bf0.bf_valid, bf0.bf_stage,
                  bf0.bf_addr_a, bf0.bf_addr_b, bf0.bf_twiddle);
         cap_a[s][k] = int'(bf0.bf_addr_a);
         cap_b[s][k] = int'(bf0.bf_addr_b);
         cap_t[s][k] = int'(bf0.bf_twiddle);
         nedge();
      end
      for (int d = 0; d < 3; d++) begin
         check($sformatf("drain s%0d d%0d valid", s, d), 32'(bf0.bf_valid), 32'd0);
         check($sformatf("drain s%0d d%0d busy", s, d), 32'(busy0), 32'd1);
         check($sformatf("drain s%0d d%0d done", s, d), 32'(done0), 32'd0);
         start_fft = poke && (d == 0);
         nedge();
      end
      start_fft = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n        = 1'b0;
      start_fft    = 1'b0;
      clear_done   = 1'b0;
      start1       = 1'b0;
      bf0.bf_ready = 1'b1;

      // Reset state
      nedge();
      check("rst valid", 32'(bf0.bf_valid), 32'd0);
      check("rst addr_a", 32'(bf0.bf_addr_a), 32'd0);
      check("rst addr_b", 32'(bf0.bf_addr_b), 32'd0);
      check("rst twiddle", 32'(bf0.bf_twiddle), 32'd0);
      check("rst stage", 32'(bf0.bf_stage), 32'd0);
      check("rst busy", 32'(busy0), 32'd0);
      check("rst done", 32'(done0), 32'd0);
      check("rst dut1 valid", 32'(bf1.bf_valid), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("rst perf", perf0, 32'd0);
`endif
      nedge();
      rst_n = 1'b1;
      nedge();
      check("idle busy", 32'(busy0), 32'd0);
      check("idle done", 32'(done0), 32'd0);

      // Full transform, bf_ready high: 4 x (8 issue + 3 drain) = 44 edges
      start_fft = 1'b1;
      nedge();
      start_fft = 1'b0;
      mark = edge_cnt;
      for (int s = 0; s < L; s++) run_stage(s, -1, 0, 1'b0);
      check("t1 latency", 32'(edge_cnt - mark), 32'd44);
      check("t1 done", 32'(done0), 32'd1);
      check("t1 busy", 32'(busy0), 32'd0);
      check("t1 valid", 32'(bf0.bf_valid), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("t1 perf", perf0, 32'd44);
`endif

      // Hand-computed address points
      check("s0k0 a", 32'(cap_a[0][0]), 32'd0);
      check("s0k0 b", 32'(cap_b[0][0]), 32'd8);
      check("s0k0 tw", 32'(cap_t[0][0]), 32'd0);
      check("s0k7 a", 32'(cap_a[0][7]), 32'd7);
      check("s0k7 b", 32'(cap_b[0][7]), 32'd15);
      check("s0k7 tw", 32'(cap_t[0][7]), 32'd7);
      check("s1k5 a", 32'(cap_a[1][5]), 32'd9);
      check("s1k5 b", 32'(cap_b[1][5]), 32'd13);
      check("s1k5 tw", 32'(cap_t[1][5]), 32'd2);
      check("s3k3 a", 32'(cap_a[3][3]), 32'd6);
      check("s3k3 b", 32'(cap_b[3][3]), 32'd7);
      check("s3k3 tw", 32'(cap_t[3][3]), 32'd0);

      // Restart from DONE (start wins over clear_done), 5-cycle stall in
      // stage 1, ignored start during the stage-1 drain: 44 + 5 = 49 edges
      start_fft  = 1'b1;
      clear_done = 1'b1;
      nedge();
      start_fft  = 1'b0;
      clear_done = 1'b0;
      mark = edge_cnt;
      check("restart done drop", 32'(done0), 32'd0);
      check("restart busy", 32'(busy0), 32'd1);
      run_stage(0, -1, 0, 1'b0);
      run_stage(1, 3, 5, 1'b1);
      run_stage(2, -1, 0, 1'b0);
      run_stage(3, -1, 0, 1'b0);
      check("bp latency", 32'(edge_cnt - mark), 32'd49);
      check("bp done", 32'(done0), 32'd1);
      check("bp busy", 32'(busy0), 32'd0);
      nedge();
      nedge();
      check("done hold", 32'(done0), 32'd1);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("bp perf hold", perf0, 32'd49);
`endif

      // clear_done in DONE -> IDLE
      clear_done = 1'b1;
      nedge();
      clear_done = 1'b0;
      check("clear done", 32'(done0), 32'd0);
      check("clear busy", 32'(busy0), 32'd0);
      check("clear valid", 32'(bf0.bf_valid), 32'd0);
      repeat (3) nedge();
      check("idle stays", 32'(done0), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("idle perf hold", perf0, 32'd49);
`endif

      // Async reset in the middle of stage 2
      start_fft = 1'b1;
      nedge();
      start_fft = 1'b0;
      run_stage(0, -1, 0, 1'b0);
      run_stage(1, -1, 0, 1'b0);
      check_bf("pre-rst", 2, 0, bf0.bf_valid, bf0.bf_stage,
               bf0.bf_addr_a, bf0.bf_addr_b, bf0.bf_twiddle);
      nedge();
      check_bf("pre-rst", 2, 1, bf0.bf_valid, bf0.bf_stage,
               bf0.bf_addr_a, bf0.bf_addr_b, bf0.bf_twiddle);
      nedge();
      #2 rst_n = 1'b0;
      #1;
      check("arst valid", 32'(bf0.bf_valid), 32'd0);
      check("arst addr_a", 32'(bf0.bf_addr_a), 32'd0);
      check("arst addr_b", 32'(bf0.bf_addr_b), 32'd0);
      check("arst twiddle", 32'(bf0.bf_twiddle), 32'd0);
      check("arst stage", 32'(bf0.bf_stage), 32'd0);
      check("arst busy", 32'(busy0), 32'd0);
      check("arst done", 32'(done0), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("arst perf", perf0, 32'd0);
`endif
      nedge();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (60) begin
         nedge();
         seen = seen | done0 | bf0.bf_valid | busy0;
      end
      check("post-rst quiet", 32'(seen), 32'd0);

      // BF_LATENCY=0: back-to-back stages, 32 edges
      start1 = 1'b1;
      nedge();
      start1 = 1'b0;
      mark = edge_cnt;
      for (int s = 0; s < L; s++) begin
         for (int k = 0; k < NB; k++) begin
            check_bf("lat0", s, k, bf1.bf_valid, bf1.bf_stage,
                     bf1.bf_addr_a, bf1.bf_addr_b, bf1.bf_twiddle);
            nedge();
         end
      end
      check("lat0 latency", 32'(edge_cnt - mark), 32'd32);
      check("lat0 done", 32'(done1), 32'd1);
      check("lat0 busy", 32'(busy1), 32'd0);
`ifdef FFT_SEQ_PERF_CNT_EN
      check("lat0 perf", perf1, 32'd32);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
